// File: rtl/agen_split_unit.sv
// Load/store address generator: decodes the request, forms the address/size/flags/lane mask and splits bus-crossing accesses into two beats.
// One-cycle latency into a single output register; input stalls while a beat is held, except on the final beat being consumed.
`ifndef SIZE_INSTRUCTION
`define SIZE_INSTRUCTION 32
`endif
`ifndef LDST_TYPES_LOG
`define LDST_TYPES_LOG 2
`endif

module agen_split_unit #(
    parameter int DATA_W   = 64,
    parameter int IMM_W    = 12,
    parameter int TAG_W    = 7,
    parameter bit SPLIT_EN = 1'b1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [DATA_W-1:0]            data1_i,
    input  logic [IMM_W-1:0]             immd_i,
    input  logic [`SIZE_INSTRUCTION-1:0] inst_i,
    input  logic [TAG_W-1:0]             tag_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [DATA_W-1:0]            address_o,
    output logic [`LDST_TYPES_LOG-1:0]   ldstSize_o,
    output logic [DATA_W/8-1:0]          byteMask_o,
    output logic [2:0]                   flags_o,
    output logic [TAG_W-1:0]             tag_o,
    output logic                         beat_o,
    output logic                         last_o,
    output logic                         misalign_o,
    output logic                         illegal_o
);
    localparam int BUS_B = DATA_W / 8;
    localparam int OFF_W = $clog2(BUS_B);
    localparam int MW    = 2 * BUS_B;
    localparam int SZW   = `LDST_TYPES_LOG;

    typedef enum logic [1:0] {EMPTY, ONE, FIRST} state_t;

    // flags = {ldSign, destValid, executed}
    typedef struct packed {
        logic [DATA_W-1:0] addr;
        logic [SZW-1:0]    size;
        logic [BUS_B-1:0]  mask;
        logic [2:0]        flags;
        logic [TAG_W-1:0]  tag;
        logic              beat;
        logic              misalign;
        logic              illegal;
    } beat_t;

    state_t            state_q, state_d;
    beat_t             out_q, out_d;
    logic [DATA_W-1:0] b1_addr_q, b1_addr_d;
    logic [BUS_B-1:0]  b1_mask_q, b1_mask_d;

    logic [6:0]        opcode;
    logic [2:0]        fn3;
    logic [4:0]        fn5;
    logic              is_mem, is_atom, crosses, do_split, accept;
    logic [SZW-1:0]    dsize;
    logic [2:0]        dflags;
    logic [DATA_W-1:0] ea, dec_b1_addr;
    logic [OFF_W-1:0]  off;
    logic [MW-1:0]     span;
    beat_t             dec_b0;
    logic              unused_inst;

    assign unused_inst = ^{inst_i[26:15], inst_i[11:7]};

    always_comb begin
        opcode  = inst_i[6:0];
        fn3     = inst_i[14:12];
        fn5     = inst_i[31:27];
        is_mem  = 1'b0;
        is_atom = 1'b0;
        dsize   = '0;
        dflags  = '0;
        case (opcode)
            7'h03, 7'h07: if (fn3 != 3'd7) begin
                is_mem = 1'b1;
                dsize  = SZW'(fn3[1:0]);
                dflags = {~fn3[2], 1'b1, 1'b0};
            end
            7'h23, 7'h27: if (!fn3[2]) begin
                is_mem = 1'b1;
                dsize  = SZW'(fn3[1:0]);
                dflags = 3'b001;
            end
            7'h2F: if (fn5 == 5'b00010) begin
                is_atom = 1'b1;
                dsize   = SZW'(2);
                dflags  = 3'b110;
            end else if (fn5 == 5'b00011) begin
                is_atom = 1'b1;
                dsize   = SZW'(2);
                dflags  = 3'b011;
            end
            default: ;
        endcase

        ea   = is_atom ? data1_i : data1_i + {{(DATA_W-IMM_W){immd_i[IMM_W-1]}}, immd_i};
        off  = ea[OFF_W-1:0];
        // Lanes spanned across two consecutive bus words; upper half belongs to the second beat.
        span = ((MW'(1) << (1 << dsize)) - MW'(1)) << off;
        crosses     = is_mem && (span[MW-1:BUS_B] != '0);
        do_split    = crosses && SPLIT_EN;
        dec_b1_addr = {ea[DATA_W-1:OFF_W], OFF_W'(0)} + DATA_W'(BUS_B);

        dec_b0     = '0;
        dec_b0.tag = tag_i;
        if (is_mem || is_atom) begin
            dec_b0.addr  = ea;
            dec_b0.size  = dsize;
            dec_b0.flags = dflags;
            dec_b0.mask  = span[BUS_B-1:0];
            if ((is_atom && ea[1:0] != 2'b00) || (crosses && !SPLIT_EN)) begin
                dec_b0.misalign = 1'b1;
                dec_b0.mask     = '0;
            end
        end else begin
            dec_b0.illegal = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        out_d      = out_q;
        b1_addr_d  = b1_addr_q;
        b1_mask_d  = b1_mask_q;
        in_ready_o = !reset && ((state_q == EMPTY) || (state_q == ONE && out_ready_i));
        accept     = in_valid_i && in_ready_o && !flush_i;
        case (state_q)
            EMPTY: ;
            ONE:   if (out_ready_i) state_d = EMPTY;
            FIRST: if (out_ready_i) begin
                state_d    = ONE;
                out_d.addr = b1_addr_q;
                out_d.mask = b1_mask_q;
                out_d.beat = 1'b1;
            end
            default: state_d = EMPTY;
        endcase
        if (accept) begin
            out_d     = dec_b0;
            b1_addr_d = dec_b1_addr;
            b1_mask_d = span[MW-1:BUS_B];
            state_d   = do_split ? FIRST : ONE;
        end
        if (flush_i) state_d = EMPTY;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= EMPTY;
            out_q     <= '0;
            b1_addr_q <= '0;
            b1_mask_q <= '0;
        end else begin
            state_q   <= state_d;
            out_q     <= out_d;
            b1_addr_q <= b1_addr_d;
            b1_mask_q <= b1_mask_d;
        end
    end

    assign out_valid_o = (state_q != EMPTY);
    assign last_o      = (state_q == ONE);
    assign address_o   = out_q.addr;
    assign ldstSize_o  = out_q.size;
    assign byteMask_o  = out_q.mask;
    assign flags_o     = out_q.flags;
    assign tag_o       = out_q.tag;
    assign beat_o      = out_q.beat;
    assign misalign_o  = out_q.misalign;
    assign illegal_o   = out_q.illegal;
endmodule

// File: tb/tb_agen_split_unit.sv
// Scoreboard bench for agen_split_unit: expected beats are queued on acceptance and a monitor compares every presented beat.
module tb_agen_split_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, flush, in_valid, in_ready_o, out_valid_o, out_ready;
    logic [63:0] data1, address_o;
    logic [11:0] immd;
    logic [31:0] inst;
    logic [6:0]  tag, tag_o;
    logic [1:0]  size_o;
    logic [7:0]  mask_o;
    logic [2:0]  flags_o;
    logic        beat_o, last_o, misalign_o, illegal_o;

    logic        in_valid0, in_ready0, out_valid0;
    logic [63:0] data10, address0;
    logic [31:0] inst0;
    logic [6:0]  tag0, tag_o0;
    logic [1:0]  size0;
    logic [7:0]  mask0;
    logic [2:0]  flags0;
    logic        beat0, last0, misalign0, illegal0;

    agen_split_unit #(.DATA_W(64), .IMM_W(12), .TAG_W(7), .SPLIT_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready_o),
        .data1_i(data1), .immd_i(immd), .inst_i(inst), .tag_i(tag),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready), .address_o(address_o),
        .ldstSize_o(size_o), .byteMask_o(mask_o), .flags_o(flags_o), .tag_o(tag_o),
        .beat_o(beat_o), .last_o(last_o), .misalign_o(misalign_o), .illegal_o(illegal_o));

    agen_split_unit #(.DATA_W(64), .IMM_W(12), .TAG_W(7), .SPLIT_EN(1'b0)) dut0 (
        .clk(clk), .reset(reset), .flush_i(1'b0), .in_valid_i(in_valid0), .in_ready_o(in_ready0),
        .data1_i(data10), .immd_i(12'h0), .inst_i(inst0), .tag_i(tag0),
        .out_valid_o(out_valid0), .out_ready_i(1'b1), .address_o(address0),
        .ldstSize_o(size0), .byteMask_o(mask0), .flags_o(flags0), .tag_o(tag_o0),
        .beat_o(beat0), .last_o(last0), .misalign_o(misalign0), .illegal_o(illegal0));

    typedef struct packed {
        logic [63:0] addr;
        logic [1:0]  size;
        logic [7:0]  mask;
        logic [2:0]  flags;   // {ldSign, destValid, executed}
        logic [6:0]  tag;
        logic        beat;
        logic        last;
        logic        misalign;
        logic        illegal;
    } bt_t;

    bt_t sb_q[$];
    bt_t stage_q[$];
    int  n_vec = 0;
    int  n_err = 0;
    bit  mon_en = 0;
    int  rdy_mode = 0;
    int  pat_idx = 0;
    bit  rdy_pat[4] = '{1'b1, 1'b0, 1'b1, 1'b1};

    function automatic void chk(string nm, logic [87:0] act, logic [87:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endfunction

    function automatic bt_t mk(logic [63:0] a, logic [1:0] s, logic [7:0] m, logic [2:0] f,
                               logic [6:0] t, logic b, logic l, logic mis, logic ill);
        bt_t r;
        r.addr = a; r.size = s; r.mask = m; r.flags = f; r.tag = t;
        r.beat = b; r.last = l; r.misalign = mis; r.illegal = ill;
        return r;
    endfunction

    function automatic bt_t dut_beat();
        return mk(address_o, size_o, mask_o, flags_o, tag_o, beat_o, last_o, misalign_o, illegal_o);
    endfunction

    function automatic bt_t dut0_beat();
        return mk(address0, size0, mask0, flags0, tag_o0, beat0, last0, misalign0, illegal0);
    endfunction

    // Reference: enumerate touched bytes one by one and bin them into bus words.
    function automatic void model(logic [31:0] ins, logic [63:0] d1, logic [11:0] imm, logic [6:0] t);
        logic [6:0]  op = ins[6:0];
        logic [2:0]  f3 = ins[14:12];
        logic [4:0]  f5 = ins[31:27];
        int          kind = -1;
        logic [1:0]  sz = 2'd0;
        logic [2:0]  fl = 3'b000;
        logic [63:0] a;
        int          n, o;
        logic [7:0]  m0 = 8'h0;
        logic [7:0]  m1 = 8'h0;
        bt_t         b;
        if ((op == 7'h03 || op == 7'h07) && f3 != 3'd7) begin
            kind = 0; sz = f3[1:0]; fl = (f3 < 3'd4) ? 3'b110 : 3'b010;
        end else if ((op == 7'h23 || op == 7'h27) && f3 <= 3'd3) begin
            kind = 0; sz = f3[1:0]; fl = 3'b001;
        end else if (op == 7'h2F && f5 == 5'd2) begin
            kind = 1; sz = 2'd2; fl = 3'b110;
        end else if (op == 7'h2F && f5 == 5'd3) begin
            kind = 1; sz = 2'd2; fl = 3'b011;
        end
        b = '0; b.tag = t; b.last = 1'b1;
        if (kind < 0) begin
            b.illegal = 1'b1;
            stage_q.push_back(b);
            return;
        end
        a = (kind == 1) ? d1 : d1 + 64'($signed(imm));
        n = 1 << sz;
        o = int'(a % 64'd8);
        for (int i = 0; i < n; i++) begin
            if (o + i < 8) m0[o+i] = 1'b1;
            else           m1[o+i-8] = 1'b1;
        end
        b.addr = a; b.size = sz; b.flags = fl;
        if (kind == 1) begin
            if (a % 64'd4 != 0) b.misalign = 1'b1;
            else                b.mask = m0;
            stage_q.push_back(b);
        end else if (m1 == 8'h0) begin
            b.mask = m0;
            stage_q.push_back(b);
        end else begin
            b.mask = m0; b.last = 1'b0;
            stage_q.push_back(b);
            b.addr = ((a / 64'd8) + 64'd1) * 64'd8;
            b.mask = m1; b.beat = 1'b1; b.last = 1'b1;
            stage_q.push_back(b);
        end
    endfunction

    initial forever begin
        @(negedge clk);
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom % 4) != 0;
            2:       begin out_ready = rdy_pat[pat_idx % 4]; pat_idx++; end
            default: out_ready = 1'b0;
        endcase
    end

    // Monitor: pop on handshake, then drop everything pending on flush.
    initial forever begin
        @(negedge clk);
        #3;
        if (mon_en) begin
            chk("in_ready", 88'(in_ready_o), 88'((sb_q.size() == 0) || (sb_q.size() == 1 && out_ready)));
            chk("out_valid", 88'(out_valid_o), 88'(sb_q.size() != 0));
            if (out_valid_o && sb_q.size() != 0) begin
                chk("beat", dut_beat(), sb_q[0]);
                if (out_ready) void'(sb_q.pop_front());
            end
            if (flush) sb_q.delete();
        end
    end

    task automatic issue(logic [31:0] ins, logic [63:0] d1, logic [11:0] imm, logic [6:0] t,
                         bit use_model, int fl_pct);
        bit done = 0;
        if (use_model) begin
            stage_q.delete();
            model(ins, d1, imm, t);
        end
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            in_valid = 1'b1; inst = ins; data1 = d1; immd = imm; tag = t;
            flush = ($urandom % 100) < fl_pct;
            #4;
            if (in_ready_o && !flush) begin
                foreach (stage_q[i]) sb_q.push_back(stage_q[i]);
                done = 1;
            end
        end
        if (!done) begin
            n_vec++; n_err++;
            $display("FAIL issue_timeout: request tag %h never accepted, expected acceptance", t);
        end
        stage_q.delete();
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0; flush = 1'b0;
        end
    endtask

    task automatic drain();
        int t = 0;
        while (sb_q.size() != 0 && t < 300) begin
            idle(1);
            t++;
        end
        if (sb_q.size() != 0) begin
            n_vec++; n_err++;
            $display("FAIL drain_timeout: %0d beats outstanding, expected 0", sb_q.size());
        end
        idle(1);
    endtask

    task automatic flush_pulse();
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; inst = 32'h0000_0023; tag = 7'h7F;
        idle(2);
    endtask

    initial begin
        logic [31:0] ri;
        logic [63:0] rd;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        data1 = '0; immd = '0; inst = '0; tag = '0;
        in_valid0 = 1'b0; data10 = '0; inst0 = '0; tag0 = '0;

        repeat (3) @(negedge clk);
        chk("reset_beat", dut_beat(), '0);
        chk("reset_handshake", 88'({out_valid_o, in_ready_o, out_valid0, in_ready0}), 88'h0);
        reset = 1'b0;
        mon_en = 1;

        // Crossing word load with splitting disabled.
        @(negedge clk);
        in_valid0 = 1'b1; inst0 = 32'h0000_2003; data10 = 64'h2006; tag0 = 7'h11;
        #4 chk("s0_in_ready", 88'(in_ready0), 88'h1);
        @(negedge clk);
        in_valid0 = 1'b0;
        #3;
        chk("s0_valid", 88'(out_valid0), 88'h1);
        chk("s0_beat", dut0_beat(), mk(64'h2006, 2'd2, 8'h00, 3'b110, 7'h11, 1'b0, 1'b1, 1'b1, 1'b0));
        @(negedge clk);
        #3 chk("s0_single", 88'(out_valid0), 88'h0);

        rdy_mode = 0;
        stage_q.push_back(mk(64'hFF8, 2'd3, 8'hFF, 3'b110, 7'h01, 1'b0, 1'b1, 1'b0, 1'b0));
        issue(32'h0000_3003, 64'h1000, 12'hFF8, 7'h01, 0, 0);
        stage_q.push_back(mk(64'h2006, 2'd2, 8'hC0, 3'b110, 7'h02, 1'b0, 1'b0, 1'b0, 1'b0));
        stage_q.push_back(mk(64'h2008, 2'd2, 8'h03, 3'b110, 7'h02, 1'b1, 1'b1, 1'b0, 1'b0));
        issue(32'h0000_2003, 64'h2006, 12'h000, 7'h02, 0, 0);
        stage_q.push_back(mk(64'h3002, 2'd2, 8'h00, 3'b110, 7'h03, 1'b0, 1'b1, 1'b1, 1'b0));
        issue(32'h1000_202F, 64'h3002, 12'h010, 7'h03, 0, 0);
        stage_q.push_back(mk(64'h3000, 2'd2, 8'h0F, 3'b011, 7'h04, 1'b0, 1'b1, 1'b0, 1'b0));
        issue(32'h1800_202F, 64'h3000, 12'h7F0, 7'h04, 0, 0);
        stage_q.push_back(mk(64'h0, 2'd0, 8'h00, 3'b000, 7'h55, 1'b0, 1'b1, 1'b0, 1'b1));
        issue(32'h0000_0033, 64'h1234, 12'h004, 7'h55, 0, 0);
        drain();

        rdy_mode = 2;
        for (int i = 0; i < 4; i++)
            issue(32'h0000_0023, 64'h5000 + 64'(i * 3), 12'(i), 7'(8'h20 + i), 1, 0);
        drain();

        // Flush while the first half of a split is held.
        rdy_mode = 3;
        issue(32'h0000_3003, 64'h4004, 12'h000, 7'h30, 1, 0);
        flush_pulse();
        rdy_mode = 0;
        issue(32'h0000_3003, 64'hFFFF_FFFF_FFFF_FFFC, 12'h000, 7'h31, 1, 0);
        drain();

        rdy_mode = 1;
        for (int i = 0; i < 400; i++) begin
            ri = $urandom;
            case ($urandom % 6)
                0: ri[6:0] = ($urandom % 2) ? 7'h03 : 7'h07;
                1: ri[6:0] = ($urandom % 2) ? 7'h23 : 7'h27;
                2: begin ri[6:0] = 7'h2F; ri[31:27] = 5'd2; end
                3: begin ri[6:0] = 7'h2F; ri[31:27] = 5'd3; end
                4: ri[6:0] = 7'h2F;
                default: ;
            endcase
            rd = {$urandom, $urandom};
            if ($urandom % 8 == 0) rd = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom % 16);
            issue(ri, rd, 12'($urandom), 7'($urandom), 1, 5);
            if ($urandom % 8 == 0) idle(1);
            if ($urandom % 40 == 0) flush_pulse();
        end
        rdy_mode = 0;
        drain();

        // Reset in the middle of a split access.
        rdy_mode = 3;
        issue(32'h0000_3003, 64'h4004, 12'h000, 7'h40, 1, 0);
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0;
        mon_en = 0;
        @(negedge clk);
        chk("midsplit_reset_beat", dut_beat(), '0);
        chk("midsplit_reset_handshake", 88'({out_valid_o, in_ready_o}), 88'h0);
        sb_q.delete();
        reset = 1'b0;
        rdy_mode = 0;
        mon_en = 1;
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/agen_split_unit.md
Name: agen_split_unit

Overview:
- Parametrised, pipelined successor to the combinational load/store address generator; sits between the LSU issue register-read stage and the LSQ/D-cache request port.
- Decodes LOAD/LOAD_FP/STORE/STORE_FP/ATOM (LR, SC), computes address, size, flags and byte mask into a one-entry output register behind valid/ready handshakes.
- New capabilities: split of bus-boundary-crossing accesses into two beats, misalignment detection, illegal-encoding reporting and flush.

Parameters:
- DATA_W, 64, operand/address width; bus width in bytes BUS_B = DATA_W/8 (power of two, 4 or 8).
- IMM_W, 12, immediate width; sign-extended to DATA_W.
- TAG_W, 7, opaque instruction tag carried through.
- SPLIT_EN, 1, 1: boundary-crossing loads/stores become two beats; 0: single beat with misalign_o=1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush_i  in  1  discard held/pending beats
- in_valid_i  in  1  request valid
- in_ready_o  out  1  unit accepts request this cycle
- data1_i  in  DATA_W  base register
- immd_i  in  IMM_W  offset
- inst_i  in  `SIZE_INSTRUCTION  raw instruction (opcode, fn3, fn5)
- tag_i  in  TAG_W  tag
- out_valid_o  out  1  output beat valid
- out_ready_i  in  1  consumer accepts beat
- address_o  out  DATA_W  beat address
- ldstSize_o  out  `LDST_TYPES_LOG  access size code
- byteMask_o  out  BUS_B  lanes touched by this beat
- flags_o  out  exeFlgs  ldSign/destValid/executed as per type
- tag_o  out  TAG_W  tag
- beat_o  out  1  0 = first/only beat, 1 = second beat
- last_o  out  1  final beat of the instruction
- misalign_o  out  1  misaligned fault
- illegal_o  out  1  undecodable encoding

Behaviour:
- Reset: all outputs 0 (in_ready_o=0 while reset is high), state EMPTY; in_ready_o=1 the cycle after reset drops.
- Address: A = data1_i + sext(immd_i), modulo 2^DATA_W. Atomics: A = data1_i, immediate ignored.
- Byte offset: o = A[log2(BUS_B)-1:0]. Size in bytes: n = 1, 2, 4 or 8.
- Decode:
  - Loads: LB/LH/LW/LD set ldSign+destValid; LBU/LHU/LWU set destValid.
  - Stores: SB/SH/SW/SD set executed.
  - LR: word, ldSign+destValid. SC: word, destValid+executed.
  - Load fn3=7, store fn3>3, ATOM fn5 other than LR/SC, or any other opcode: single beat, illegal_o=1, address/size/flags/mask 0, tag passed.
- Latency: 1 cycle; a request accepted in cycle t is presented at t+1.
- Handshakes:
  - in_ready_o = (state==EMPTY) | (state==ONE & out_ready_i).
  - Acceptance requires in_valid_i & in_ready_o & !flush_i.
  - Output holds stable while out_valid_o & !out_ready_i.
- States:
  - EMPTY: out_valid_o=0. On accept, go to FIRST if crossing and split, else ONE.
  - ONE: single or last beat held, last_o=1. On out handshake, load a new request if accepted (back-to-back, no bubble), else EMPTY.
  - FIRST: beat_o=0, last_o=0. On out handshake go to ONE, presenting beat 1.
- Crossing: o+n > BUS_B, loads and stores only.
  - Beat 0: address=A, mask = lanes o..BUS_B-1.
  - Beat 1: address=(A & ~(BUS_B-1))+BUS_B with wrap, mask = lanes 0..o+n-BUS_B-1, beat_o=1.
  - Flags, size and tag are identical on both beats.
- Non-crossing: mask = lanes o..o+n-1, single beat.
- Atomics: A not 4-byte aligned gives misalign_o=1, single beat, never split, mask 0.
- SPLIT_EN=0 with crossing: single beat, misalign_o=1, mask 0.
- Flush: next state EMPTY, out_valid_o=0 next cycle, and a same-cycle input is dropped, even mid-split (beat 1 discarded). Reset has priority over flush.

Test Plan:
- LD, data1=0x1000, imm=-8 -> after 1 cycle: address 0xFF8, size DOUBLE, mask 0xFF, ldSign=destValid=1, last_o=1.
- LW, data1=0x2006, SPLIT_EN=1, out_ready held 1 -> beat0 0x2006 mask 0xC0 last=0; beat1 0x2008 mask 0x03 beat_o=1 last=1; in_ready_o=0 during beat0.
- Same LW with SPLIT_EN=0 -> single beat, misalign_o=1, mask 0.
- LR with data1=0x3002 -> misalign_o=1, single beat. SC with data1=0x3000 -> destValid=executed=1, mask 0x0F.
- SB stream of 4 with out_ready toggling 1,0,1,1 -> no loss or duplicates, outputs stable while stalled, back-to-back in ONE state. Opcode 0x33 -> illegal_o=1, tag preserved.
- Split LD at 0x4004 with flush_i during beat0 -> out_valid_o=0 next cycle, no beat1. Reset asserted mid-split -> all outputs 0.
